cpu_bus_sequencer: RTL and testbench



---
 rtl/cpu_bus_sequencer_pkg.sv | 17 +
 rtl/cpu_bus_sequencer_addr_step.sv | 19 +
 rtl/cpu_bus_sequencer.sv | 175 +++++++++++++++++
 tb/tb_cpu_bus_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_sequencer_pkg.sv
// Shared definitions for the CPU bus-access sequencer: bus FSM encodings and
// request length codes (byte count minus one).
package cpu_bus_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StStrobe = 2'd2,
    StDone   = 2'd3
  } bus_state_e;

  localparam logic [1:0] LEN_1 = 2'd0;
  localparam logic [1:0] LEN_2 = 2'd1;
  localparam logic [1:0] LEN_3 = 2'd2;
  localparam logic [1:0] LEN_4 = 2'd3;

endpackage

// File: rtl/cpu_bus_sequencer_addr_step.sv
// Combinational next-byte address, optionally wrapping inside the 256-byte page
// as 6502 indirect/zero-page accesses do.
module cpu_bus_addr_step #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              page_wrap_i,
  output logic [ADDR_W-1:0] addr_o
);

  always_comb begin
    if (page_wrap_i) begin
      addr_o = {addr_i[ADDR_W-1:8], addr_i[7:0] + 8'd1};
    end else begin
      addr_o = addr_i + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/cpu_bus_sequencer.sv
// Splits one CPU request of 1..MAX_BYTES bytes into byte-wide strobe/ready bus
// beats, little-endian, with an optional per-beat timeout that ends the request.
module cpu_bus_sequencer
  import cpu_bus_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned MAX_BYTES      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                         i_cpu_clk,
  input  logic                         i_rst,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic                         i_req_we,
  input  logic [ADDR_W-1:0]            i_req_addr,
  input  logic [$clog2(MAX_BYTES)-1:0] i_req_len,
  input  logic                         i_req_page_wrap,
  input  logic [8*MAX_BYTES-1:0]       i_req_wdata,
  output logic                         o_rsp_valid,
  output logic [8*MAX_BYTES-1:0]       o_rsp_rdata,
  output logic                         o_rsp_err,
  output logic                         o_bus_clk,
  output logic                         o_bus_we,
  output logic [ADDR_W-1:0]            o_bus_addr,
  output logic [7:0]                   o_bus_data,
  input  logic [7:0]                   i_bus_data,
  input  logic                         i_bus_data_ready
);

  localparam int unsigned LenW  = $clog2(MAX_BYTES);
  localparam int unsigned DataW = 8 * MAX_BYTES;
  localparam int unsigned ToW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);

  bus_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [LenW-1:0]   len_q, len_d;
  logic              wrap_q, wrap_d;
  logic [DataW-1:0]  wdata_q, wdata_d;
  logic [LenW-1:0]   beat_q, beat_d;
  logic [ToW-1:0]    to_q, to_d;
  logic [DataW-1:0]  acc_q, acc_d;
  logic [DataW-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              bus_clk_q, bus_clk_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [7:0]        bus_data_q, bus_data_d;
  logic [ADDR_W-1:0] addr_next;

  cpu_bus_addr_step #(
    .ADDR_W(ADDR_W)
  ) u_addr_step (
    .addr_i     (bus_addr_q),
    .page_wrap_i(wrap_q),
    .addr_o     (addr_next)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    len_d       = len_q;
    wrap_d      = wrap_q;
    wdata_d     = wdata_q;
    beat_d      = beat_q;
    to_d        = to_q;
    acc_d       = acc_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    bus_clk_d   = bus_clk_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_data_d  = bus_data_q;

    unique case (state_q)
      StIdle: begin
        if (i_req_valid) begin
          we_d       = i_req_we;
          len_d      = i_req_len;
          wrap_d     = i_req_page_wrap;
          wdata_d    = i_req_wdata;
          beat_d     = '0;
          acc_d      = '0;
          bus_addr_d = i_req_addr;
          bus_we_d   = i_req_we;
          bus_data_d = i_req_wdata[7:0];
          state_d    = StSetup;
        end
      end
      StSetup: begin
        bus_clk_d = 1'b1;
        to_d      = '0;
        state_d   = StStrobe;
      end
      StStrobe: begin
        if (i_bus_data_ready) begin
          if (!we_q) begin
            acc_d[{beat_q, 3'b000} +: 8] = i_bus_data;
          end
          bus_clk_d = 1'b0;
          if (beat_q == len_q) begin
            rsp_rdata_d = acc_d;
            rsp_err_d   = 1'b0;
            bus_we_d    = 1'b0;
            state_d     = StDone;
          end else begin
            beat_d     = beat_q + LenW'(1);
            bus_addr_d = addr_next;
            bus_data_d = wdata_q[{beat_d, 3'b000} +: 8];
            state_d    = StSetup;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (to_q == ToLast)) begin
          // Abandon the request: keep lanes already captured, issue no more beats.
          bus_clk_d   = 1'b0;
          rsp_rdata_d = acc_q;
          rsp_err_d   = 1'b1;
          bus_we_d    = 1'b0;
          state_d     = StDone;
        end else begin
          to_d = to_q + ToW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_cpu_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      len_q       <= '0;
      wrap_q      <= 1'b0;
      wdata_q     <= '0;
      beat_q      <= '0;
      to_q        <= '0;
      acc_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      bus_clk_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      len_q       <= len_d;
      wrap_q      <= wrap_d;
      wdata_q     <= wdata_d;
      beat_q      <= beat_d;
      to_q        <= to_d;
      acc_q       <= acc_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      bus_clk_q   <= bus_clk_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_data_q  <= bus_data_d;
    end
  end

  assign o_req_ready = (state_q == StIdle);
  assign o_rsp_valid = (state_q == StDone);
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_bus_clk   = bus_clk_q;
  assign o_bus_we    = bus_we_q;
  assign o_bus_addr  = bus_addr_q;
  assign o_bus_data  = bus_data_q;

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Directed bench for cpu_bus_sequencer: a vector table of whole requests with a
// bus responder, plus hand sequences for mid-request reset and back-to-back issue.
module tb_cpu_bus_sequencer;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic [1:0]  i_req_len = '0;
  logic        i_req_page_wrap = 1'b0;
  logic [31:0] i_req_wdata = '0;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_bus_clk;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [7:0]  o_bus_data;
  logic [7:0]  i_bus_data = '0;
  logic        i_bus_data_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_bus_sequencer #(
    .ADDR_W        (32),
    .MAX_BYTES     (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_cpu_clk       (clk),
    .i_rst           (i_rst),
    .i_req_valid     (i_req_valid),
    .o_req_ready     (o_req_ready),
    .i_req_we        (i_req_we),
    .i_req_addr      (i_req_addr),
    .i_req_len       (i_req_len),
    .i_req_page_wrap (i_req_page_wrap),
    .i_req_wdata     (i_req_wdata),
    .o_rsp_valid     (o_rsp_valid),
    .o_rsp_rdata     (o_rsp_rdata),
    .o_rsp_err       (o_rsp_err),
    .o_bus_clk       (o_bus_clk),
    .o_bus_we        (o_bus_we),
    .o_bus_addr      (o_bus_addr),
    .o_bus_data      (o_bus_data),
    .i_bus_data      (i_bus_data),
    .i_bus_data_ready(i_bus_data_ready)
  );

  // hi: cycles o_bus_clk stays high per beat before ready (0 = never ready).
  // noise: level driven on ready while o_bus_clk is low.
  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [1:0]   len;
    logic         wrap;
    logic [31:0]  wdata;
    logic [31:0]  bus_rd;
    int           hi;
    logic         noise;
    logic [31:0]  exp_rdata;
    logic         exp_err;
    int           exp_beats;
    int           exp_lat;
    logic [127:0] exp_addrs;
  } vec_t;

  localparam int NumVec = 10;
  vec_t vecs [NumVec];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!o_req_ready && t < 100) begin
      step();
      t++;
    end
    check("wait_idle", 32'(o_req_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   k;
    int   rises;
    int   age;
    int   hi_cnt;
    logic prev_clk;
    bit   done;
    wait_idle();
    i_req_valid     = 1'b1;
    i_req_we        = v.we;
    i_req_addr      = v.addr;
    i_req_len       = v.len;
    i_req_page_wrap = v.wrap;
    i_req_wdata     = v.wdata;
    i_bus_data_ready = v.noise;
    step();
    i_req_valid = 1'b0;
    k = 0; rises = 0; age = 0; hi_cnt = 0; prev_clk = 1'b0; done = 1'b0;
    while (!done && k < 100) begin
      if (o_bus_clk) begin
        if (!prev_clk) begin
          rises++;
          age = 0;
          if (rises <= v.exp_beats) begin
            check($sformatf("v%0d bus_addr b%0d", idx, rises - 1), o_bus_addr,
                  v.exp_addrs[32*(rises-1) +: 32]);
            check($sformatf("v%0d bus_we b%0d", idx, rises - 1), 32'(o_bus_we), 32'(v.we));
            if (v.we) begin
              check($sformatf("v%0d bus_data b%0d", idx, rises - 1), 32'(o_bus_data),
                    32'(v.wdata[8*(rises-1) +: 8]));
            end
          end
        end
        age++;
        hi_cnt++;
        i_bus_data_ready = (v.hi != 0) && (age >= v.hi);
        i_bus_data       = v.bus_rd[8*(rises-1) +: 8];
      end else begin
        i_bus_data_ready = v.noise;
        i_bus_data       = 8'hEE;
      end
      if (o_rsp_valid) begin
        done = 1'b1;
        check($sformatf("v%0d latency", idx), 32'(k), 32'(v.exp_lat));
        check($sformatf("v%0d rdata", idx), o_rsp_rdata, v.exp_rdata);
        check($sformatf("v%0d err", idx), 32'(o_rsp_err), 32'(v.exp_err));
        check($sformatf("v%0d beats", idx), 32'(rises), 32'(v.exp_beats));
        check($sformatf("v%0d strobe_cycles", idx), 32'(hi_cnt), 32'(v.exp_lat - v.exp_beats));
      end
      prev_clk = o_bus_clk;
      if (!done) begin
        step();
        k++;
      end
    end
    if (!done) check($sformatf("v%0d rsp_timeout", idx), 32'(done), 32'd1);
    i_bus_data_ready = 1'b0;
    step();
    check($sformatf("v%0d rsp_pulse_end", idx), 32'(o_rsp_valid), 32'd0);
    check($sformatf("v%0d ready_back", idx), 32'(o_req_ready), 32'd1);
    check($sformatf("v%0d rdata_held", idx), o_rsp_rdata, v.exp_rdata);
  endtask

  initial begin
    int   rises;
    int   acc_cnt;
    int   second_at;
    int   rsp_at;
    bit   rsp_seen;
    logic prev_clk;
    logic rb;

    //         we addr          len wrap wdata          bus_rd         hi  nz  exp_rdata      err bt lat addrs
    vecs[0] = '{1'b0, 32'h0000_0200, 2'd0, 1'b0, 32'h0, 32'h0000_00A9, 1, 1'b0, 32'h0000_00A9,
                1'b0, 1, 2, {96'h0, 32'h0000_0200}};
    vecs[1] = '{1'b1, 32'h0000_00FE, 2'd3, 1'b1, 32'hDDCC_BBAA, 32'h0, 1, 1'b0, 32'h0,
                1'b0, 4, 8, {32'h01, 32'h00, 32'hFF, 32'hFE}};
    vecs[2] = '{1'b1, 32'h0000_00FE, 2'd3, 1'b0, 32'hDDCC_BBAA, 32'h0, 1, 1'b0, 32'h0,
                1'b0, 4, 8, {32'h101, 32'h100, 32'hFF, 32'hFE}};
    vecs[3] = '{1'b0, 32'h0000_FFFC, 2'd1, 1'b0, 32'h0, 32'h0000_8000, 3, 1'b0, 32'h0000_8000,
                1'b0, 2, 8, {64'h0, 32'hFFFD, 32'hFFFC}};
    vecs[4] = '{1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0, 32'h0033_2211, 0, 1'b0, 32'h0,
                1'b1, 1, 17, {96'h0, 32'h10}};
    vecs[5] = '{1'b0, 32'h0000_0020, 2'd0, 1'b0, 32'h0, 32'h0000_005A, 16, 1'b0, 32'h0000_005A,
                1'b0, 1, 17, {96'h0, 32'h20}};
    vecs[6] = '{1'b0, 32'h0000_12FF, 2'd1, 1'b1, 32'h0, 32'h0000_2211, 1, 1'b1, 32'h0000_2211,
                1'b0, 2, 4, {64'h0, 32'h1200, 32'h12FF}};
    vecs[7] = '{1'b0, 32'h0000_1000, 2'd3, 1'b0, 32'h0, 32'h0403_0201, 2, 1'b0, 32'h0403_0201,
                1'b0, 4, 12, {32'h1003, 32'h1002, 32'h1001, 32'h1000}};
    vecs[8] = '{1'b0, 32'hFFFF_FFFF, 2'd1, 1'b0, 32'h0, 32'h0000_BEEF, 1, 1'b1, 32'h0000_BEEF,
                1'b0, 2, 4, {64'h0, 32'h0000_0000, 32'hFFFF_FFFF}};
    vecs[9] = '{1'b0, 32'h0000_30FE, 2'd2, 1'b1, 32'h0, 32'hFFC3_B2A1, 1, 1'b0, 32'h00C3_B2A1,
                1'b0, 3, 6, {32'h0, 32'h3000, 32'h30FF, 32'h30FE}};

    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    check("rst req_ready", 32'(o_req_ready), 32'd1);
    check("rst rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst rsp_err", 32'(o_rsp_err), 32'd0);
    check("rst rsp_rdata", o_rsp_rdata, 32'd0);
    check("rst bus_clk", 32'(o_bus_clk), 32'd0);
    check("rst bus_we", 32'(o_bus_we), 32'd0);
    check("rst bus_addr", o_bus_addr, 32'd0);
    check("rst bus_data", 32'(o_bus_data), 32'd0);

    for (int i = 0; i < NumVec; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset during the strobe of beat 1 of a 4-byte read.
    wait_idle();
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h0000_0500;
    i_req_len = 2'd3; i_req_page_wrap = 1'b0; i_bus_data = 8'h33;
    step();
    i_req_valid = 1'b0;
    rises = 0; prev_clk = 1'b0;
    for (int t = 0; t < 20 && rises < 2; t++) begin
      if (o_bus_clk && !prev_clk) rises++;
      prev_clk = o_bus_clk;
      i_bus_data_ready = o_bus_clk && (rises < 2);
      if (rises < 2) step();
    end
    check("rstmid reached_beat1", 32'(rises), 32'd2);
    i_bus_data_ready = 1'b0;
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("rstmid bus_clk", 32'(o_bus_clk), 32'd0);
    check("rstmid req_ready", 32'(o_req_ready), 32'd1);
    check("rstmid bus_addr", o_bus_addr, 32'd0);
    rsp_seen = o_rsp_valid;
    for (int t = 0; t < 10; t++) begin
      step();
      if (o_rsp_valid) rsp_seen = 1'b1;
    end
    check("rstmid no_rsp", 32'(rsp_seen), 32'd0);

    // Requester holds valid across two 2-byte reads; ready stays high everywhere.
    wait_idle();
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h0000_0040;
    i_req_len = 2'd1; i_req_page_wrap = 1'b0;
    i_bus_data = 8'h77; i_bus_data_ready = 1'b1;
    acc_cnt = 0; second_at = -1; rsp_at = -1;
    for (int k = 0; k < 40 && second_at < 0; k++) begin
      rb = o_req_ready;
      step();
      if (rb) begin
        if (acc_cnt == 1) second_at = k;
        acc_cnt++;
      end
      if (o_rsp_valid && rsp_at < 0) begin
        rsp_at = k;
        check("b2b rdata", o_rsp_rdata, 32'h0000_7777);
        check("b2b err", 32'(o_rsp_err), 32'd0);
      end
    end
    i_req_valid = 1'b0;
    check("b2b second_accept", 32'(second_at), 32'd6);
    check("b2b first_rsp", 32'(rsp_at), 32'd4);
    rsp_seen = 1'b0;
    for (int t = 0; t < 20 && !rsp_seen; t++) begin
      step();
      if (o_rsp_valid) rsp_seen = 1'b1;
    end
    check("b2b second_rsp", 32'(rsp_seen), 32'd1);
    i_bus_data_ready = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
